// File: rtl/masked_count_decoder.sv
// masked_count_decoder
// Rebuilds a full-width running count from a stream that carries only its
// low IN_W bits. Upper bits are regenerated by counting wrap-arounds of the
// low field. The decoder locks after two consecutive in-sequence samples and
// reports sequence breaks while locked through a pulse and a saturating counter.
module masked_count_decoder #(
    parameter int IN_W  = 3,
    parameter int EXT_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [EXT_W-1:0] out_data,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int HI_W = EXT_W - IN_W;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        CHECK  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [IN_W-1:0]   prev_r;
    logic [IN_W-1:0]   prev_nx_s;
    logic [HI_W-1:0]   hi_r;
    logic [HI_W-1:0]   hi_nx_s;
    logic              out_valid_r;
    logic              out_valid_nx_s;
    logic [EXT_W-1:0]  out_data_r;
    logic [EXT_W-1:0]  out_data_nx_s;
    logic              locked_r;
    logic              locked_nx_s;
    logic              seq_err_r;
    logic              seq_err_nx_s;
    logic [ERR_W-1:0]  err_count_r;
    logic [ERR_W-1:0]  err_count_nx_s;

    logic [IN_W-1:0]   exp_s;
    logic              match_s;
    logic              wrap_s;
    logic [HI_W-1:0]   hi_wrap_s;

    // Expected next sample, wrap detection and the upper bits after a wrap
    always_comb begin
        exp_s   = prev_r + IN_W'(1);
        match_s = (in_data == exp_s);
        wrap_s  = (in_data == {IN_W{1'b0}}) && (prev_r == {IN_W{1'b1}});
        if (wrap_s) begin
            hi_wrap_s = hi_r + HI_W'(1);
        end else begin
            hi_wrap_s = hi_r;
        end
    end

    // Next-state and next-output logic; everything holds when no sample arrives
    always_comb begin
        state_nx_s     = state_r;
        prev_nx_s      = prev_r;
        hi_nx_s        = hi_r;
        out_valid_nx_s = 1'b0;
        out_data_nx_s  = out_data_r;
        locked_nx_s    = locked_r;
        seq_err_nx_s   = 1'b0;
        err_count_nx_s = err_count_r;
        if (in_valid) begin
            prev_nx_s = in_data;
            case (state_r)
                SEARCH: begin
                    state_nx_s = CHECK;
                end
                CHECK: begin
                    if (match_s) begin
                        state_nx_s     = LOCKED;
                        hi_nx_s        = hi_wrap_s;
                        out_valid_nx_s = 1'b1;
                        out_data_nx_s  = {hi_wrap_s, in_data};
                        locked_nx_s    = 1'b1;
                    end else begin
                        state_nx_s = CHECK;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        state_nx_s     = LOCKED;
                        hi_nx_s        = hi_wrap_s;
                        out_valid_nx_s = 1'b1;
                        out_data_nx_s  = {hi_wrap_s, in_data};
                    end else begin
                        state_nx_s   = CHECK;
                        locked_nx_s  = 1'b0;
                        seq_err_nx_s = 1'b1;
                        if (err_count_r != {ERR_W{1'b1}}) begin
                            err_count_nx_s = err_count_r + ERR_W'(1);
                        end else begin
                            err_count_nx_s = err_count_r;
                        end
                    end
                end
                default: begin
                    state_nx_s  = SEARCH;
                    locked_nx_s = 1'b0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SEARCH;
            prev_r      <= {IN_W{1'b0}};
            hi_r        <= {HI_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {EXT_W{1'b0}};
            locked_r    <= 1'b0;
            seq_err_r   <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            prev_r      <= prev_nx_s;
            hi_r        <= hi_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_data_r  <= out_data_nx_s;
            locked_r    <= locked_nx_s;
            seq_err_r   <= seq_err_nx_s;
            err_count_r <= err_count_nx_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign locked    = locked_r;
    assign seq_err   = seq_err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_masked_count_decoder.sv
// Scoreboard bench for masked_count_decoder. Two instances share the same
// stimulus: the default one (ERR_W=8) and one with ERR_W=2 for saturation.
module tb_masked_count_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;

    logic       out_valid,  seq_err,  locked;
    logic [3:0] out_data;
    logic [7:0] err_count;
    logic       out_valid2, seq_err2, locked2;
    logic [3:0] out_data2;
    logic [1:0] err_count2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       is_err;
        logic [3:0] data;
        logic [7:0] e8;
        logic [1:0] e2;
    } exp_t;

    exp_t exp_q[$];

    masked_count_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .locked(locked),
        .seq_err(seq_err), .err_count(err_count)
    );

    masked_count_decoder #(.IN_W(3), .EXT_W(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_data(out_data2), .locked(locked2),
        .seq_err(seq_err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop an expectation whenever either DUT presents an output event
    always @(negedge clk) begin
        exp_t e;
        if (out_valid || seq_err || out_valid2 || seq_err2) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {out_valid, seq_err, out_data}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_valid", out_valid, !e.is_err);
                check("seq_err",   seq_err,   e.is_err);
                check("locked",    locked,    !e.is_err);
                check("err_count", err_count, e.e8);
                check("err_count_sat", err_count2, e.e2);
                check("seq_err_sat",   seq_err2,   e.is_err);
                if (!e.is_err) begin
                    check("out_data", out_data, e.data);
                end
            end
        end
    end

    // ev: 0 = no output expected, 1 = out_valid with od, 2 = seq_err pulse
    task automatic apply(input logic v, input logic [2:0] d, input int ev,
                         input logic [3:0] od, input logic [7:0] e8, input logic [1:0] e2);
        exp_t e;
        in_valid = v;
        in_data  = d;
        if (ev != 0) begin
            e.is_err = (ev == 2);
            e.data   = od;
            e.e8     = e8;
            e.e2     = e2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic [2:0] d);
        rst      = 1'b1;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  4'd0);
        check("rst_locked",    locked,    1'b0);
        check("rst_seq_err",   seq_err,   1'b0);
        check("rst_err_count", err_count, 8'd0);
        check("rst_err_count_sat", err_count2, 2'd0);
    endtask

    initial begin
        logic [3:0] cnt;
        @(posedge clk);
        #1;
        do_reset(1'b0, 3'd0);

        // Consecutive 0..7,0..7,0,1: outputs 1..15,0,1
        for (int i = 0; i < 18; i++) begin
            cnt = 4'(i);
            if (i == 0) apply(1'b1, cnt[2:0], 0, 4'd0, 8'd0, 2'd0);
            else        apply(1'b1, cnt[2:0], 1, cnt, 8'd0, 2'd0);
        end
        check("locked_after_run", locked, 1'b1);

        // Same stream with idle cycles between samples (garbage data while idle)
        do_reset(1'b0, 3'd0);
        for (int i = 0; i < 18; i++) begin
            cnt = 4'(i);
            if (i == 0) apply(1'b1, cnt[2:0], 0, 4'd0, 8'd0, 2'd0);
            else        apply(1'b1, cnt[2:0], 1, cnt, 8'd0, 2'd0);
            apply(1'b0, 3'b101, 0, 4'd0, 8'd0, 2'd0);
            if (i > 0) check("locked_idle", locked, 1'b1);
        end

        // Locked at 3, then break with 5, re-lock with 6
        do_reset(1'b0, 3'd0);
        apply(1'b1, 3'd0, 0, 4'd0, 8'd0, 2'd0);
        apply(1'b1, 3'd1, 1, 4'd1, 8'd0, 2'd0);
        apply(1'b1, 3'd2, 1, 4'd2, 8'd0, 2'd0);
        apply(1'b1, 3'd3, 1, 4'd3, 8'd0, 2'd0);
        apply(1'b1, 3'd5, 2, 4'd0, 8'd1, 2'd1);
        check("locked_dropped", locked, 1'b0);
        apply(1'b1, 3'd6, 1, 4'd6, 8'd1, 2'd1);

        // Six breaks each followed by re-lock; ERR_W=2 saturates at 3
        do_reset(1'b0, 3'd0);
        apply(1'b1, 3'd0, 0, 4'd0, 8'd0, 2'd0);
        apply(1'b1, 3'd1, 1, 4'd1, 8'd0, 2'd0);
        apply(1'b1, 3'd3, 2, 4'd0, 8'd1, 2'd1);
        apply(1'b1, 3'd4, 1, 4'd4, 8'd1, 2'd1);
        apply(1'b1, 3'd6, 2, 4'd0, 8'd2, 2'd2);
        apply(1'b1, 3'd7, 1, 4'd7, 8'd2, 2'd2);
        apply(1'b1, 3'd1, 2, 4'd0, 8'd3, 2'd3);
        apply(1'b1, 3'd2, 1, 4'd2, 8'd3, 2'd3);
        apply(1'b1, 3'd4, 2, 4'd0, 8'd4, 2'd3);
        apply(1'b1, 3'd5, 1, 4'd5, 8'd4, 2'd3);
        apply(1'b1, 3'd7, 2, 4'd0, 8'd5, 2'd3);
        apply(1'b1, 3'd0, 1, 4'd8, 8'd5, 2'd3);   // wrap and lock together
        apply(1'b1, 3'd0, 2, 4'd0, 8'd6, 2'd3);   // repeated value
        apply(1'b1, 3'd1, 1, 4'd9, 8'd6, 2'd3);   // hi kept across lock loss

        // Mid-stream reset at out_data=12 with a sample present
        do_reset(1'b0, 3'd0);
        for (int i = 0; i < 13; i++) begin
            cnt = 4'(i);
            if (i == 0) apply(1'b1, cnt[2:0], 0, 4'd0, 8'd0, 2'd0);
            else        apply(1'b1, cnt[2:0], 1, cnt, 8'd0, 2'd0);
        end
        do_reset(1'b1, 3'd5);
        apply(1'b1, 3'd6, 0, 4'd0, 8'd0, 2'd0);
        apply(1'b1, 3'd7, 1, 4'd7, 8'd0, 2'd0);

        // Free-running 4-bit counter masked to 3 bits, 64 cycles
        do_reset(1'b0, 3'd0);
        cnt = 4'd0;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) apply(1'b1, cnt[2:0], 0, 4'd0, 8'd0, 2'd0);
            else        apply(1'b1, cnt[2:0], 1, cnt, 8'd0, 2'd0);
            cnt = cnt + 4'd1;
        end

        apply(1'b0, 3'd0, 0, 4'd0, 8'd0, 2'd0);
        apply(1'b0, 3'd0, 0, 4'd0, 8'd0, 2'd0);
        check("pending_expectations", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
